// File: rtl/instr_mem_loader.sv
// Byte-stream boot loader: assembles little-endian 32-bit words from an 8-bit
// stream and writes them to instruction memory, holding the CPU until it is done.
module instr_mem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   cfg_words,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       checksum
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RECV  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_COUNT  = (ADDR_W+1)'(1);

    logic [1:0]        state;
    logic [1:0]        byte_cnt;
    logic [31:0]       word_buf;
    logic [ADDR_W-1:0] word_addr;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W:0]   start_count;

    assign start_count = (cfg_words > FULL_COUNT) ? FULL_COUNT : cfg_words;

    assign in_ready  = (state == RECV);
    // NOTE: abort gates the write enable combinationally so an aborted WRITE never lands.
    assign mem_we    = (state == WRITE) && !abort;
    assign mem_addr  = word_addr;
    assign mem_wdata = word_buf;
    assign busy      = (state != IDLE);
    assign cpu_hold  = busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            byte_cnt  <= 2'd0;
            word_buf  <= 32'd0;
            word_addr <= '0;
            remaining <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            checksum  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        done      <= (start_count == '0);
                        err       <= 1'b0;
                        checksum  <= 32'd0;
                        byte_cnt  <= 2'd0;
                        word_buf  <= 32'd0;
                        word_addr <= '0;
                        remaining <= start_count;
                        if (start_count != '0) state <= RECV;
                    end
                end
                RECV: begin
                    if (abort) begin
                        state    <= IDLE;
                        err      <= 1'b1;
                        done     <= 1'b0;
                        byte_cnt <= 2'd0;
                    end else if (in_valid) begin
                        word_buf[{byte_cnt, 3'b000} +: 8] <= in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) state <= WRITE;
                    end
                end
                WRITE: begin
                    if (abort) begin
                        state    <= IDLE;
                        err      <= 1'b1;
                        done     <= 1'b0;
                        byte_cnt <= 2'd0;
                    end else begin
                        checksum  <= checksum ^ word_buf;
                        remaining <= remaining - ONE_COUNT;
                        byte_cnt  <= 2'd0;
                        // The address stays on the last word so a full-depth load never wraps.
                        if (remaining == ONE_COUNT) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            state     <= RECV;
                            word_addr <= word_addr + ADDR_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed and randomized loads
// compared against a word-level reference model built from the byte stream.
module tb_instr_mem_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [7:0] byte_q_t[$];

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W:0]   cfg_words = '0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       checksum;

    instr_mem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .cfg_words (cfg_words),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Every cycle with mem_we high is logged as one memory write.
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    // Reference model: word i is bytes 4i..4i+3, little-endian.
    function automatic logic [31:0] model_word(input byte_q_t b, input int i);
        return 32'(b[4*i]) + (32'(b[4*i+1]) << 8) + (32'(b[4*i+2]) << 16) + (32'(b[4*i+3]) << 24);
    endfunction

    function automatic logic [31:0] model_checksum(input byte_q_t b, input int n);
        logic [31:0] c = 32'd0;
        for (int i = 0; i < n; i++) c = c ^ model_word(b, i);
        return c;
    endfunction

    function automatic byte_q_t random_bytes(input int n);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic start_load(input logic [ADDR_W:0] cfg);
        start     = 1'b1;
        cfg_words = cfg;
        @(posedge clk); #1;
        start     = 1'b0;
        cfg_words = $urandom;
    endtask

    // mode 0: back-to-back, 1: valid every other cycle, 2: random valid.
    task automatic feed_bytes(input byte_q_t b, input int mode, output bit timed_out);
        int  idx = 0;
        int  cyc = 0;
        bit  take;
        bit  consumed;
        timed_out = 1'b0;
        while (idx < b.size()) begin
            case (mode)
                0:       take = 1'b1;
                1:       take = (cyc % 2 == 0);
                default: take = 1'($urandom_range(0, 1));
            endcase
            in_valid = take;
            in_data  = take ? b[idx] : 8'($urandom);
            @(negedge clk);
            consumed = in_valid && in_ready;
            @(posedge clk); #1;
            if (consumed) idx++;
            cyc++;
            if (cyc > 40 * b.size() + 20) begin
                timed_out = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit timed_out);
        int cyc = 0;
        while (busy && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        timed_out = busy;
    endtask

    task automatic check_load(input string name, input byte_q_t b, input int n, input bit to);
        tests++;
        if (to) begin
            fails++;
            $display("FAIL %s timeout: load did not finish within its cycle budget", name);
        end
        tests++;
        if (wr_addr_q.size() !== n) begin
            fails++;
            $display("FAIL %s write_count: got %0d, want %0d", name, wr_addr_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                tests++;
                if (wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== model_word(b, i)) begin
                    fails++;
                    $display("FAIL %s write[%0d]: got %h@%0d, want %h@%0d",
                             name, i, wr_data_q[i], wr_addr_q[i], model_word(b, i), i);
                end
            end
        end
        tests++;
        if (checksum !== model_checksum(b, n) || done !== 1'b1 || err !== 1'b0 ||
            busy !== 1'b0 || cpu_hold !== 1'b0) begin
            fails++;
            $display("FAIL %s final: got cs=%h done=%b err=%b busy=%b hold=%b, want cs=%h done=1 err=0 busy=0 hold=0",
                     name, checksum, done, err, busy, cpu_hold, model_checksum(b, n));
        end
    endtask

    task automatic test_reset();
        #3;
        tests++;
        if ({in_ready, mem_we, cpu_hold, busy, done, err} !== 6'b0 ||
            mem_addr !== '0 || mem_wdata !== 32'd0 || checksum !== 32'd0) begin
            fails++;
            $display("FAIL reset_state: got rdy=%b we=%b hold=%b busy=%b done=%b err=%b addr=%0d wd=%h cs=%h, want all 0",
                     in_ready, mem_we, cpu_hold, busy, done, err, mem_addr, mem_wdata, checksum);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_idle: got busy=%b rdy=%b, want 0 0", busy, in_ready);
        end
    endtask

    task automatic test_directed(input int mode, input string name);
        byte_q_t b = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        bit to1, to2;
        clear_log();
        start_load((ADDR_W+1)'(2));
        tests++;
        if (busy !== 1'b1 || cpu_hold !== 1'b1 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s started: got busy=%b hold=%b rdy=%b, want 1 1 1", name, busy, cpu_hold, in_ready);
        end
        feed_bytes(b, mode, to1);
        wait_idle(to2);
        check_load(name, b, 2, to1 | to2);
        tests++;
        if (checksum !== 32'hCC99E897) begin
            fails++;
            $display("FAIL %s checksum_const: got %h, want cc99e897", name, checksum);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int n = $urandom_range(1, 6);
            byte_q_t b = random_bytes(4 * n);
            bit to1, to2;
            clear_log();
            start_load((ADDR_W+1)'(n));
            feed_bytes(b, $urandom_range(0, 2), to1);
            wait_idle(to2);
            check_load("random", b, n, to1 | to2);
        end
    endtask

    task automatic test_zero_count();
        clear_log();
        start_load('0);
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL zero_count: got done=%b busy=%b err=%b, want 1 0 0", done, busy, err);
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (wr_addr_q.size() !== 0) begin
            fails++;
            $display("FAIL zero_count_writes: got %0d, want 0", wr_addr_q.size());
        end
    endtask

    task automatic test_full_load();
        byte_q_t b = random_bytes(4 * DEPTH);
        bit to1, to2;
        clear_log();
        start_load((ADDR_W+1)'(2047));
        feed_bytes(b, 0, to1);
        wait_idle(to2);
        check_load("full_load", b, DEPTH, to1 | to2);
        tests++;
        if (wr_addr_q.size() == 0 || wr_addr_q[wr_addr_q.size()-1] !== ADDR_W'(DEPTH - 1)) begin
            fails++;
            $display("FAIL full_load_last_addr: got %0d writes, want last at %0d", wr_addr_q.size(), DEPTH - 1);
        end
    endtask

    task automatic test_abort_partial();
        byte_q_t b = random_bytes(8);
        byte_q_t six;
        bit to;
        for (int i = 0; i < 6; i++) six.push_back(b[i]);
        clear_log();
        start_load((ADDR_W+1)'(2));
        feed_bytes(six, 0, to);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        tests++;
        if (to || busy !== 1'b0 || err !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL abort_partial_state: got busy=%b err=%b done=%b to=%b, want 0 1 0 0", busy, err, done, to);
        end
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (wr_addr_q.size() !== 1 || wr_addr_q[0] !== '0 || wr_data_q[0] !== model_word(b, 0)) begin
            fails++;
            $display("FAIL abort_partial_writes: got %0d writes, want 1 write of %h at 0",
                     wr_addr_q.size(), model_word(b, 0));
        end
    endtask

    task automatic test_abort_write();
        byte_q_t b = random_bytes(4);
        bit to;
        clear_log();
        start_load((ADDR_W+1)'(2));
        feed_bytes(b, 0, to);
        tests++;
        if (to || busy !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL abort_write_pre: got busy=%b rdy=%b, want 1 0 (write cycle)", busy, in_ready);
        end
        abort = 1'b1;
        @(negedge clk);
        tests++;
        if (mem_we !== 1'b0) begin
            fails++;
            $display("FAIL abort_write_we: got mem_we=%b, want 0", mem_we);
        end
        @(posedge clk); #1;
        abort = 1'b0;
        tests++;
        if (wr_addr_q.size() !== 0 || err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_write_post: got writes=%0d err=%b done=%b busy=%b, want 0 1 0 0",
                     wr_addr_q.size(), err, done, busy);
        end
    endtask

    task automatic test_abort_idle();
        repeat (2) begin
            abort = 1'b1;
            @(posedge clk); #1;
        end
        abort = 1'b0;
        tests++;
        if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle: got done=%b err=%b busy=%b, want 1 0 0", done, err, busy);
        end
    endtask

    task automatic test_async_reset();
        byte_q_t b = random_bytes(5);
        byte_q_t fresh = random_bytes(4);
        bit to1, to2;
        start_load((ADDR_W+1)'(3));
        feed_bytes(b, 0, to1);
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if ({in_ready, mem_we, cpu_hold, busy, done, err} !== 6'b0 ||
            mem_addr !== '0 || mem_wdata !== 32'd0 || checksum !== 32'd0) begin
            fails++;
            $display("FAIL async_reset: got rdy=%b we=%b hold=%b busy=%b done=%b err=%b addr=%0d wd=%h cs=%h, want all 0",
                     in_ready, mem_we, cpu_hold, busy, done, err, mem_addr, mem_wdata, checksum);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL async_reset_waits: got busy=%b, want 0", busy);
        end
        clear_log();
        start_load((ADDR_W+1)'(1));
        feed_bytes(fresh, 2, to1);
        wait_idle(to2);
        check_load("post_reset_load", fresh, 1, to1 | to2);
    endtask

    task automatic test_start_ignored();
        byte_q_t b = random_bytes(12);
        byte_q_t first;
        byte_q_t rest;
        bit to1, to2, to3;
        for (int i = 0; i < 6; i++) first.push_back(b[i]);
        for (int i = 6; i < 12; i++) rest.push_back(b[i]);
        clear_log();
        start_load((ADDR_W+1)'(3));
        feed_bytes(first, 0, to1);
        start_load((ADDR_W+1)'(1));
        feed_bytes(rest, 1, to2);
        wait_idle(to3);
        check_load("start_ignored", b, 3, to1 | to2 | to3);
    endtask

    initial begin
        test_reset();
        test_directed(0, "back_to_back");
        test_directed(1, "backpressure");
        test_abort_idle();
        test_random();
        test_abort_partial();
        test_zero_count();
        test_abort_write();
        test_start_ignored();
        test_async_reset();
        test_full_load();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter ADDR_W, default 10, meaning word-address width of the instruction memory (depth 2^ADDR_W words).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 start  input  1  one-cycle request to begin a load; sampled in IDLE only.
REQ-005 abort  input  1  cancels a load in progress.
REQ-006 cfg_words  input  ADDR_W+1  number of 32-bit words to load; sampled when start is accepted.
REQ-007 in_valid  input  1  byte-stream source has a byte.
REQ-008 in_data  input  8  byte-stream data.
REQ-009 in_ready  output  1  loader accepts a byte this cycle.
REQ-010 mem_we  output  1  instruction-memory write enable.
REQ-011 mem_addr  output  ADDR_W  instruction-memory word address.
REQ-012 mem_wdata  output  32  instruction-memory write data.
REQ-013 cpu_hold  output  1  holds the fetch path (PC) in reset while loading.
REQ-014 busy  output  1  load in progress.
REQ-015 done  output  1  last load completed; sticky until next accepted start.
REQ-016 err  output  1  last load was aborted; sticky until next accepted start.
REQ-017 checksum  output  32  XOR of all words written in the current/last load.

Function
REQ-018 FSM states SHALL be IDLE, RECV, WRITE.
REQ-019 In IDLE, start=1 SHALL be accepted: clear done, err, checksum, byte counter, word address; latch word count = min(cfg_words, 2^ADDR_W).
REQ-020 Accepted start with latched count 0 SHALL stay in IDLE and set done=1 on the next cycle, with no writes.
REQ-021 Accepted start with count >0 SHALL enter RECV on the next edge.
REQ-022 start while busy=1 SHALL be ignored.
REQ-023 In RECV, in_ready SHALL be 1; a byte is consumed only when in_valid=1 and in_ready=1 in the same cycle.
REQ-024 Bytes SHALL assemble little-endian: 1st byte -> bits [7:0], 2nd -> [15:8], 3rd -> [23:16], 4th -> [31:24].
REQ-025 Consuming the 4th byte SHALL move the FSM to WRITE on the next edge.
REQ-026 WRITE SHALL last exactly one cycle: mem_we=1, mem_addr=current word address, mem_wdata=assembled word, in_ready=0.
REQ-027 On leaving WRITE: checksum ^= word, word address +1, remaining count -1, byte counter 0.
REQ-028 After WRITE, remaining count 0 SHALL go to IDLE with done=1; otherwise back to RECV.
REQ-029 Word address SHALL never wrap within a load; a full 2^ADDR_W-word load ends at address 2^ADDR_W-1.
REQ-030 mem_we SHALL be 0 outside WRITE; mem_addr/mem_wdata are don't-care when mem_we=0 but SHALL hold registered values (no combinational path from in_data).
REQ-031 busy and cpu_hold SHALL be 1 exactly in RECV and WRITE.
REQ-032 abort in RECV or WRITE SHALL return to IDLE on the next edge, set err=1, leave done=0, discard any partial word; a WRITE coinciding with abort SHALL still not assert mem_we (abort has priority).
REQ-033 abort in IDLE SHALL have no effect.
REQ-034 Back-pressure: in_valid may drop mid-word; byte counter and partial word SHALL hold indefinitely.

Reset
REQ-035 rst=0 SHALL asynchronously force IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, busy=0, done=0, err=0, checksum=0, counters 0.
REQ-036 Reset mid-load SHALL discard all progress; no write occurs in the reset cycle; after release the block waits for start.

Verification
REQ-037 Load 2 words, bytes 78 56 34 12 EF BE AD DE streamed back-to-back -> writes 0x12345678 @0 then 0xDEADBEEF @1, mem_we one cycle each, done=1, checksum=0xCC99E897, busy/cpu_hold=0 after.
REQ-038 Same 2-word load with in_valid toggling every other cycle -> identical writes and checksum, no byte lost or duplicated.
REQ-039 start with cfg_words=0 -> no mem_we, done=1 next cycle; cfg_words=2047 -> exactly 1024 writes, last at address 1023.
REQ-040 abort after 6 bytes of a 2-word load -> one write (@0) only, err=1, done=0, IDLE next cycle; abort coinciding with WRITE -> no write that cycle.
REQ-041 rst=0 pulsed asynchronously (between edges) during RECV -> all outputs reset immediately; subsequent fresh load from address 0 succeeds.
REQ-042 start pulsed again mid-load -> ignored; load completes with original count.
